// File: rtl/uarc_pkg.sv
// Shared types for the UARC receive endpoint: FIFO word entry and ack classification.
// The entry layout follows the package widths, which are also the receiver's default parameters.
package uarc_pkg;

  localparam int UARC_WORD_MAG       = 5;
  localparam int UARC_WORD_WIDTH     = 1 << UARC_WORD_MAG;
  localparam int UARC_BUS_IDX_WIDTH  = 2;

  typedef struct packed {
    logic [UARC_WORD_WIDTH-1:0]    data;
    logic [UARC_BUS_IDX_WIDTH-1:0] bus;
    logic                          last;
  } uarc_word_entry_t;

  typedef enum logic [1:0] {
    ACK_NONE   = 2'd0,
    ACK_SEND   = 2'd1,
    ACK_STREAM = 2'd2
  } uarc_ack_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder: index of the lowest set request bit, plus any-hit flag.
module priority_encoder #(
  parameter int WIDTH       = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [WIDTH-1:0]       requests,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = {INDEX_WIDTH{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      index = requests[i] ? INDEX_WIDTH'(i) : index;
    end
    valid = |requests;
  end

endmodule

// File: rtl/uarc_fifo.sv
// Synchronous FIFO with async reset, synchronous flush and push/pop in the same cycle when full.
module uarc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int                DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO  = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE     = ADDR_WIDTH'(1'b1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  assign full      = (count_r == COUNT_FULL);
  assign empty     = (count_r == COUNT_ZERO);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; pointers wrap naturally at the address width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; left unreset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/uarc_receiver.sv
// Receive-side UARC endpoint: arbitrates kill/incept/send requests, returns one-cycle acks,
// queues accepted words and holds the pending incept and kill flag for the owning core.
module uarc_receiver
  import uarc_pkg::*;
#(
  parameter int WORD_MAG        = UARC_WORD_MAG,
  parameter int TOTAL_BUSES     = 4,
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int BUS_IDX_WIDTH   = UARC_BUS_IDX_WIDTH,
  localparam int WORD_WIDTH     = 1 << WORD_MAG
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [TOTAL_BUSES-1:0]            receiver_enable,
  input  logic [TOTAL_BUSES-1:0]            receiver_kills,
  output logic [TOTAL_BUSES-1:0]            receiver_kill_acks,
  input  logic [TOTAL_BUSES-1:0]            receiver_incepts,
  output logic [TOTAL_BUSES-1:0]            receiver_incept_acks,
  input  logic [TOTAL_BUSES-1:0]            receiver_sends,
  output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
  input  logic [TOTAL_BUSES-1:0]            receiver_streams,
  output logic [TOTAL_BUSES-1:0]            receiver_stream_acks,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_incept_permissions,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_incept_addresses,
  input  logic [TOTAL_BUSES-1:0]            accept_mask,
  output logic                              out_valid,
  output logic [WORD_WIDTH-1:0]             out_data,
  output logic [BUS_IDX_WIDTH-1:0]          out_bus,
  output logic                              out_last,
  input  logic                              out_pop,
  output logic                              incept_valid,
  output logic [WORD_WIDTH-1:0]             incept_permission,
  output logic [WORD_WIDTH-1:0]             incept_address,
  input  logic                              incept_taken,
  output logic                              kill_pending,
  input  logic                              kill_clear
);

  localparam logic [TOTAL_BUSES-1:0]   BUS_NONE = {TOTAL_BUSES{1'b0}};
  localparam logic [TOTAL_BUSES-1:0]   BUS_ALL  = {TOTAL_BUSES{1'b1}};
  localparam logic [TOTAL_BUSES-1:0]   BUS_ONE  = TOTAL_BUSES'(1'b1);
  localparam logic [BUS_IDX_WIDTH-1:0] IDX_ZERO = {BUS_IDX_WIDTH{1'b0}};
  localparam logic [WORD_WIDTH-1:0]    WORD_ZERO = {WORD_WIDTH{1'b0}};

  logic [TOTAL_BUSES-1:0]   blackout_r;
  logic [TOTAL_BUSES-1:0]   kill_acks_r, incept_acks_r, send_acks_r, stream_acks_r;
  logic                     locked_r;
  logic [BUS_IDX_WIDTH-1:0] lock_bus_r;
  logic                     kill_pending_r;
  logic                     incept_valid_r;
  logic [WORD_WIDTH-1:0]    incept_permission_r, incept_address_r;

  logic [TOTAL_BUSES-1:0]   qualified_s, kill_req_s, incept_req_s, send_req_s, lock_filter_s;
  logic [TOTAL_BUSES-1:0]   kill_onehot_s, incept_onehot_s, send_onehot_s;
  logic [BUS_IDX_WIDTH-1:0] kill_idx_s, incept_idx_s, send_idx_s;
  logic                     kill_hit_s, incept_hit_s, send_hit_s;
  logic                     incept_accept_s, send_accept_s, send_stream_s, can_push_s;
  logic                     fifo_full_s, fifo_empty_s;
  uarc_ack_t                ack_kind_s;
  uarc_word_entry_t         push_entry_s, head_entry_s;

  // A bus accepted last cycle sits out one cycle so its sender can observe the ack.
  assign qualified_s   = receiver_enable & ~blackout_r;
  assign lock_filter_s = locked_r ? (BUS_ONE << lock_bus_r) : BUS_ALL;
  assign kill_req_s    = receiver_kills & qualified_s;
  assign incept_req_s  = receiver_incepts & qualified_s;
  assign send_req_s    = receiver_sends & accept_mask & qualified_s & lock_filter_s;

  priority_encoder #(.WIDTH(TOTAL_BUSES), .INDEX_WIDTH(BUS_IDX_WIDTH)) u_kill_pe (
    .requests(kill_req_s), .index(kill_idx_s), .valid(kill_hit_s)
  );
  priority_encoder #(.WIDTH(TOTAL_BUSES), .INDEX_WIDTH(BUS_IDX_WIDTH)) u_incept_pe (
    .requests(incept_req_s), .index(incept_idx_s), .valid(incept_hit_s)
  );
  priority_encoder #(.WIDTH(TOTAL_BUSES), .INDEX_WIDTH(BUS_IDX_WIDTH)) u_send_pe (
    .requests(send_req_s), .index(send_idx_s), .valid(send_hit_s)
  );

  assign can_push_s      = ~fifo_full_s | (out_pop & ~fifo_empty_s);
  assign incept_accept_s = incept_hit_s & (~incept_valid_r | incept_taken);
  assign send_accept_s   = send_hit_s & can_push_s & ~kill_hit_s;
  assign send_stream_s   = receiver_streams[send_idx_s];
  assign kill_onehot_s   = kill_hit_s ? (BUS_ONE << kill_idx_s) : BUS_NONE;
  assign incept_onehot_s = incept_accept_s ? (BUS_ONE << incept_idx_s) : BUS_NONE;
  assign send_onehot_s   = send_accept_s ? (BUS_ONE << send_idx_s) : BUS_NONE;

  // Classify the send ack and build the FIFO entry for the winning bus.
  always_comb begin
    ack_kind_s        = ACK_NONE;
    push_entry_s.data = receiver_datas[send_idx_s*WORD_WIDTH +: WORD_WIDTH];
    push_entry_s.bus  = send_idx_s;
    push_entry_s.last = ~send_stream_s;
    if (send_accept_s) begin
      ack_kind_s = send_stream_s ? ACK_STREAM : ACK_SEND;
    end else begin
      ack_kind_s = ACK_NONE;
    end
  end

  uarc_fifo #(.DATA_WIDTH($bits(uarc_word_entry_t)), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (kill_hit_s),
    .push     (send_accept_s),
    .push_data(push_entry_s),
    .pop      (out_pop),
    .pop_data (head_entry_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // One-cycle acks, next-cycle blackout and the stream lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_acks_r   <= BUS_NONE;
      incept_acks_r <= BUS_NONE;
      send_acks_r   <= BUS_NONE;
      stream_acks_r <= BUS_NONE;
      blackout_r    <= BUS_NONE;
      locked_r      <= 1'b0;
      lock_bus_r    <= IDX_ZERO;
    end else begin
      kill_acks_r   <= kill_onehot_s;
      incept_acks_r <= incept_onehot_s;
      blackout_r    <= kill_onehot_s | incept_onehot_s | send_onehot_s;
      case (ack_kind_s)
        ACK_SEND: begin
          send_acks_r   <= send_onehot_s;
          stream_acks_r <= BUS_NONE;
        end
        ACK_STREAM: begin
          send_acks_r   <= BUS_NONE;
          stream_acks_r <= send_onehot_s;
        end
        default: begin
          send_acks_r   <= BUS_NONE;
          stream_acks_r <= BUS_NONE;
        end
      endcase
      if (kill_hit_s) begin
        locked_r <= 1'b0;
      end else if (send_accept_s) begin
        locked_r   <= send_stream_s;
        lock_bus_r <= send_idx_s;
      end
    end
  end

  // Kill flag and pending incept held for the core; a new kill beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_pending_r      <= 1'b0;
      incept_valid_r      <= 1'b0;
      incept_permission_r <= WORD_ZERO;
      incept_address_r    <= WORD_ZERO;
    end else begin
      kill_pending_r <= kill_hit_s | (kill_pending_r & ~kill_clear);
      if (incept_accept_s) begin
        incept_valid_r      <= 1'b1;
        incept_permission_r <= receiver_incept_permissions[incept_idx_s*WORD_WIDTH +: WORD_WIDTH];
        incept_address_r    <= receiver_incept_addresses[incept_idx_s*WORD_WIDTH +: WORD_WIDTH];
      end else if (incept_taken) begin
        incept_valid_r <= 1'b0;
      end
    end
  end

  assign receiver_kill_acks   = kill_acks_r;
  assign receiver_incept_acks = incept_acks_r;
  assign receiver_send_acks   = send_acks_r;
  assign receiver_stream_acks = stream_acks_r;
  assign out_valid            = ~fifo_empty_s;
  assign out_data             = head_entry_s.data;
  assign out_bus              = head_entry_s.bus;
  assign out_last             = head_entry_s.last;
  assign incept_valid         = incept_valid_r;
  assign incept_permission    = incept_permission_r;
  assign incept_address       = incept_address_r;
  assign kill_pending         = kill_pending_r;

endmodule

// File: tb/tb_uarc_receiver.sv
// Self-checking bench for uarc_receiver: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model of the receiver's rules.
module tb_uarc_receiver;

  localparam int NB = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NB-1:0]   receiver_enable, receiver_kills, receiver_incepts, receiver_sends;
  logic [NB-1:0]   receiver_streams, accept_mask;
  logic [NB-1:0]   receiver_kill_acks, receiver_incept_acks, receiver_send_acks, receiver_stream_acks;
  logic [NB*W-1:0] receiver_datas, receiver_incept_permissions, receiver_incept_addresses;
  logic            out_valid, out_last, out_pop;
  logic [W-1:0]    out_data;
  logic [1:0]      out_bus;
  logic            incept_valid, incept_taken, kill_pending, kill_clear;
  logic [W-1:0]    incept_permission, incept_address;

  always #5 clk = ~clk;

  uarc_receiver dut (
    .clk(clk), .reset(reset),
    .receiver_enable(receiver_enable),
    .receiver_kills(receiver_kills), .receiver_kill_acks(receiver_kill_acks),
    .receiver_incepts(receiver_incepts), .receiver_incept_acks(receiver_incept_acks),
    .receiver_sends(receiver_sends), .receiver_send_acks(receiver_send_acks),
    .receiver_streams(receiver_streams), .receiver_stream_acks(receiver_stream_acks),
    .receiver_datas(receiver_datas),
    .receiver_incept_permissions(receiver_incept_permissions),
    .receiver_incept_addresses(receiver_incept_addresses),
    .accept_mask(accept_mask),
    .out_valid(out_valid), .out_data(out_data), .out_bus(out_bus), .out_last(out_last),
    .out_pop(out_pop),
    .incept_valid(incept_valid), .incept_permission(incept_permission),
    .incept_address(incept_address), .incept_taken(incept_taken),
    .kill_pending(kill_pending), .kill_clear(kill_clear)
  );

  typedef struct {
    logic [W-1:0] data;
    int           bus;
    bit           last;
  } ent_t;

  ent_t         mq[$];
  bit           m_kill, m_inc_v;
  logic [W-1:0] m_perm, m_addr;
  int           m_lock;
  bit [NB-1:0]  m_bo;
  logic [NB-1:0] e_kill, e_inc, e_send, e_stream;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_kill = 1'b0; m_inc_v = 1'b0; m_perm = '0; m_addr = '0;
    m_lock = -1; m_bo = '0;
    e_kill = '0; e_inc = '0; e_send = '0; e_stream = '0;
  endtask

  task automatic compare_all();
    check("kill_acks", receiver_kill_acks, e_kill);
    check("incept_acks", receiver_incept_acks, e_inc);
    check("send_acks", receiver_send_acks, e_send);
    check("stream_acks", receiver_stream_acks, e_stream);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_data", out_data, mq[0].data);
      check("out_bus", out_bus, mq[0].bus);
      check("out_last", out_last, mq[0].last);
    end
    check("incept_valid", incept_valid, m_inc_v);
    if (m_inc_v) begin
      check("incept_perm", incept_permission, m_perm);
      check("incept_addr", incept_address, m_addr);
    end
    check("kill_pending", kill_pending, m_kill);
  endtask

  // Advance one clock; inputs are held across the edge, so the model reads them afterwards.
  task automatic step();
    int k = -1, ic = -1, s = -1;
    bit [NB-1:0] bo_n = '0;
    ent_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      bit q = receiver_enable[i] && !m_bo[i];
      if (k < 0 && q && receiver_kills[i]) k = i;
      if (ic < 0 && q && receiver_incepts[i] && (!m_inc_v || incept_taken)) ic = i;
      if (s < 0 && q && receiver_sends[i] && accept_mask[i] && (m_lock < 0 || m_lock == i)) s = i;
    end
    if (s >= 0 && !(mq.size() < 4 || (out_pop && mq.size() > 0))) s = -1;
    e_kill = '0; e_inc = '0; e_send = '0; e_stream = '0;
    if (k >= 0) begin
      e_kill[k] = 1'b1; bo_n[k] = 1'b1;
      mq.delete(); m_lock = -1; m_kill = 1'b1;
    end else begin
      if (kill_clear) m_kill = 1'b0;
      if (out_pop && mq.size() > 0) void'(mq.pop_front());
      if (s >= 0) begin
        e.data = receiver_datas[s*W +: W];
        e.bus  = s;
        e.last = !receiver_streams[s];
        mq.push_back(e);
        bo_n[s] = 1'b1;
        if (receiver_streams[s]) begin e_stream[s] = 1'b1; m_lock = s; end
        else begin e_send[s] = 1'b1; m_lock = -1; end
      end
    end
    if (ic >= 0) begin
      e_inc[ic] = 1'b1; bo_n[ic] = 1'b1; m_inc_v = 1'b1;
      m_perm = receiver_incept_permissions[ic*W +: W];
      m_addr = receiver_incept_addresses[ic*W +: W];
    end else if (incept_taken) begin
      m_inc_v = 1'b0;
    end
    m_bo = bo_n;
    compare_all();
  endtask

  task automatic clear_inputs();
    receiver_enable = '1; receiver_kills = '0; receiver_incepts = '0; receiver_sends = '0;
    receiver_streams = '0; accept_mask = '1; out_pop = 1'b0; incept_taken = 1'b0;
    kill_clear = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    receiver_datas = '0; receiver_incept_permissions = '0; receiver_incept_addresses = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;

    // Single send on bus 2
    accept_mask = 4'b0100; receiver_sends = 4'b0100;
    receiver_datas[2*W +: W] = 32'hDEADBEEF;
    step();
    check("p1_send_ack", receiver_send_acks, 4'b0100);
    check("p1_data", out_data, 32'hDEADBEEF);
    check("p1_bus", out_bus, 2'd2);
    check("p1_last", out_last, 1'b1);
    receiver_sends = '0; accept_mask = '1; out_pop = 1'b1;
    step();
    out_pop = 1'b0;

    // Buses 1 and 3 together
    receiver_datas[1*W +: W] = 32'h11111111; receiver_datas[3*W +: W] = 32'h33333333;
    receiver_sends = 4'b1010;
    step();
    check("p2_first_ack", receiver_send_acks, 4'b0010);
    step();
    check("p2_second_ack", receiver_send_acks, 4'b1000);
    check("p2_head_bus", out_bus, 2'd1);
    receiver_sends = '0; out_pop = 1'b1;
    step();
    check("p2_next_bus", out_bus, 2'd3);
    step();
    out_pop = 1'b0;

    // Bus 0 streams three words while bus 1 waits
    receiver_sends = 4'b0011; receiver_streams = 4'b0001;
    receiver_datas[0*W +: W] = 32'hA0000001; receiver_datas[1*W +: W] = 32'hB0000001;
    step(); check("p3_w1_stream", receiver_stream_acks, 4'b0001);
    step(); check("p3_hold1", receiver_send_acks, 4'b0000);
    receiver_datas[0*W +: W] = 32'hA0000002;
    step(); check("p3_w2_stream", receiver_stream_acks, 4'b0001);
    step(); check("p3_hold2", receiver_send_acks, 4'b0000);
    receiver_datas[0*W +: W] = 32'hA0000003; receiver_streams = 4'b0000;
    step(); check("p3_w3_send", receiver_send_acks, 4'b0001);
    receiver_sends = 4'b0010;
    step(); check("p3_bus1_send", receiver_send_acks, 4'b0010);
    receiver_sends = '0; out_pop = 1'b1;
    repeat (5) step();
    out_pop = 1'b0;

    // Fill the FIFO, then a send while full, then push and pop together
    for (int b = 0; b < NB; b++) begin
      receiver_sends = NB'(1) << b;
      receiver_datas[b*W +: W] = 32'hC0000000 + b;
      step();
    end
    receiver_sends = 4'b0001; receiver_datas[0*W +: W] = 32'hC0000010;
    step(); check("p4_full_noack", receiver_send_acks, 4'b0000);
    out_pop = 1'b1;
    step(); check("p4_pushpop_ack", receiver_send_acks, 4'b0001);
    check("p4_valid", out_valid, 1'b1);
    receiver_sends = '0;
    step(); step();
    out_pop = 1'b0;

    // Kill on bus 3 with two words queued
    receiver_kills = 4'b1000;
    step();
    check("p5_kill_ack", receiver_kill_acks, 4'b1000);
    check("p5_kill_pending", kill_pending, 1'b1);
    check("p5_flushed", out_valid, 1'b0);
    receiver_kills = '0; kill_clear = 1'b1;
    step(); check("p5_cleared", kill_pending, 1'b0);
    kill_clear = 1'b0;

    // Incept blocked while one is pending, accepted once taken
    receiver_incepts = 4'b0001;
    receiver_incept_permissions[0*W +: W] = 32'hA; receiver_incept_addresses[0*W +: W] = 32'h200;
    step();
    receiver_incepts = 4'b0010;
    receiver_incept_permissions[1*W +: W] = 32'h5; receiver_incept_addresses[1*W +: W] = 32'h100;
    step(); check("p6_blocked", receiver_incept_acks, 4'b0000);
    step(); check("p6_still_blocked", receiver_incept_acks, 4'b0000);
    incept_taken = 1'b1;
    step();
    check("p6_ack", receiver_incept_acks, 4'b0010);
    check("p6_perm", incept_permission, 32'h5);
    check("p6_addr", incept_address, 32'h100);
    clear_inputs();
    incept_taken = 1'b1;
    step();

    // Random traffic with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NB; b++) begin
        receiver_enable[b]  = ($urandom_range(0, 7) != 0);
        receiver_kills[b]   = ($urandom_range(0, 40) == 0);
        receiver_incepts[b] = ($urandom_range(0, 7) == 0);
        receiver_sends[b]   = ($urandom_range(0, 1) == 0);
        receiver_streams[b] = ($urandom_range(0, 2) == 0);
        accept_mask[b]      = ($urandom_range(0, 5) != 0);
        receiver_datas[b*W +: W]              = $urandom;
        receiver_incept_permissions[b*W +: W] = $urandom;
        receiver_incept_addresses[b*W +: W]   = $urandom;
      end
      out_pop      = ($urandom_range(0, 2) == 0);
      incept_taken = ($urandom_range(0, 3) == 0);
      kill_clear   = ($urandom_range(0, 3) == 0);
      if (c == 700) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uarc_receiver.md
Name: uarc_receiver

Overview:
- Receive-side endpoint of the UARC bus, the opposite end of a core's sender_* / global_* outputs.
- Samples per-bus kill, incept, send and stream requests, arbitrates them and returns the matching one-cycle acks.
- Buffers accepted send/stream words in a FIFO, and holds a pending incept and a kill flag for the owning core to consume.

Parameters:
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
- TOTAL_BUSES, 4, number of incoming buses (>=1).
- FIFO_ADDR_WIDTH, 2, log2 of the word FIFO depth (default depth 4).
- BUS_IDX_WIDTH, 2, width of the bus index; must satisfy 2^BUS_IDX_WIDTH >= TOTAL_BUSES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- receiver_enable  in  TOTAL_BUSES  bus is driven by a sender this cycle.
- receiver_kills  in  TOTAL_BUSES  kill request per bus.
- receiver_kill_acks  out  TOTAL_BUSES  one-cycle kill acknowledge.
- receiver_incepts  in  TOTAL_BUSES  incept request per bus.
- receiver_incept_acks  out  TOTAL_BUSES  one-cycle incept acknowledge.
- receiver_sends  in  TOTAL_BUSES  single-word send request.
- receiver_send_acks  out  TOTAL_BUSES  one-cycle send acknowledge.
- receiver_streams  in  TOTAL_BUSES  stream-continuation flag; qualifies a send.
- receiver_stream_acks  out  TOTAL_BUSES  one-cycle acknowledge for a stream word.
- receiver_datas  in  TOTAL_BUSES x WORD_WIDTH  send data.
- receiver_incept_permissions  in  TOTAL_BUSES x WORD_WIDTH  incept permission.
- receiver_incept_addresses  in  TOTAL_BUSES x WORD_WIDTH  incept address.
- accept_mask  in  TOTAL_BUSES  core's bus_selections / interrupt_enables for send acceptance.
- out_valid  out  1  FIFO head valid.
- out_data  out  WORD_WIDTH  FIFO head word.
- out_bus  out  BUS_IDX_WIDTH  source bus of the head word.
- out_last  out  1  head word ends its transfer (stream flag was low).
- out_pop  in  1  consume the head; ignored when out_valid=0.
- incept_valid / incept_permission / incept_address  out  1/WORD_WIDTH/WORD_WIDTH  pending incept.
- incept_taken  in  1  clears the pending incept.
- kill_pending  out  1  kill received, not yet cleared.
- kill_clear  in  1  clears kill_pending.

Behaviour:
- Reset: all acks 0, FIFO empty, out_valid 0, incept_valid 0, kill_pending 0, stream lock cleared, blackout cleared.
- Request qualification: a request on bus i counts only if receiver_enable[i]=1. Acks are registered, high in the cycle after acceptance, for exactly one cycle.
- Blackout: a bus accepted in cycle N is ignored in cycle N+1, so the sender sees the ack and updates. Maximum rate is 1 word per 2 cycles per bus.
- Kill (highest priority): the lowest-index qualified kill is accepted. Effects:
  - kill_pending is set and kill_ack is raised.
  - The FIFO and stream lock are flushed the same edge.
  - No send is accepted that cycle.
  - kill_clear and a new kill in the same cycle: set wins.
- Incept:
  - Accepted only when incept_valid=0 or incept_taken=1 that cycle; lowest index first.
  - Permission and address are latched; incept_valid is set and incept_ack is raised.
  - Incept runs independently of the send path; it is evaluated alongside sends in the same cycle.
- Send arbitration:
  - Candidates are buses with sends & enable & accept_mask & ~blackout.
  - When locked, only the lock bus is a candidate.
  - Lowest index wins (reuse priority_encoder).
  - A send is accepted only if the FIFO is not full, or out_pop=1 in the same cycle (simultaneous push/pop at full is allowed).
- Word entry: {data, bus, last = ~stream}. Ack goes on send_acks if stream=0, else on stream_acks.
- Stream lock: a word accepted with stream=1 locks the arbiter to that bus. An accepted word with stream=0 releases it; the release takes effect the next cycle.
- Full: requests stay pending with no ack, and the sender holds its signals.
- Empty: out_valid=0 and out_pop is ignored.
- FIFO pointers wrap modulo 2^FIFO_ADDR_WIDTH; the occupancy counter is FIFO_ADDR_WIDTH+1 bits wide.
- Reset mid-transfer: everything clears asynchronously and the sender must re-present its request.

Decomposition:
- uarc_pkg holds:
  - typedef uarc_word_entry_t {data, bus, last};
  - ack-type enum (ACK_NONE, ACK_SEND, ACK_STREAM).
- Sub-module uarc_fifo: parameterised synchronous FIFO with async reset, full/empty, and simultaneous push/pop.
- The existing priority_encoder is instanced for kill, incept and send selection.

Test Plan:
- Bus 2 send, data 0xDEADBEEF, stream 0, mask 0b0100 -> send_acks=0b0100 one cycle later; out_valid=1, out_data=0xDEADBEEF, out_bus=2, out_last=1.
- Buses 1 and 3 send together, mask 0b1111 -> bus 1 acked first; bus 3 acked 1 cycle later; FIFO order 1 then 3.
- Bus 0 streams 3 words (stream 1,1,0) while bus 1 sends -> bus 1 not acked until the final bus-0 word; stream_acks twice, then send_ack; bus 1 accepted 1 cycle after release.
- FIFO filled with 4 words, no pop, 5th send on bus 0 -> no ack while full; pop with send in the same cycle -> ack, count stays 4.
- Kill on bus 3 with 2 words queued -> kill_acks=0b1000, kill_pending=1, out_valid=0 next cycle.
- Incept on bus 1 (perm 0x5, addr 0x100) with incept_valid already 1 -> no ack; after incept_taken, ack and new values latched.
